// File: rtl/prog_sequence_generator_if.sv
// Bus bundle for prog_sequence_generator: control, table write port and sequence outputs.
interface prog_sequence_generator_if #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              enable;
  logic [1:0]        mode;
  logic              start;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [WIDTH-1:0]  seq_out;
  logic [ADDR_W-1:0] seq_idx;
  logic              seq_valid;
  logic              done;

  modport master (
    output enable, mode, start, wr_en, wr_addr, wr_data,
    input  seq_out, seq_idx, seq_valid, done
  );

  modport slave (
    input  enable, mode, start, wr_en, wr_addr, wr_data,
    output seq_out, seq_idx, seq_valid, done
  );
endinterface

// File: rtl/prog_sequence_generator.sv
// Programmable DEPTH x WIDTH sequence generator with up/down/ping-pong/one-shot stepping.
// Optional feature: define SEQGEN_PINGPONG_EN to build the ping-pong direction register.
module prog_sequence_generator #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  prog_sequence_generator_if.slave     bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] IDX_ZERO  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(DEPTH - 1);

  localparam logic [1:0] MODE_UP_WRAP   = 2'b00;
  localparam logic [1:0] MODE_DOWN_WRAP = 2'b01;
  localparam logic [1:0] MODE_PINGPONG  = 2'b10;
  localparam logic [1:0] MODE_ONE_SHOT  = 2'b11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] idx_r;
  logic              done_r;
  logic [WIDTH-1:0]  table_r [DEPTH];

`ifdef SEQGEN_PINGPONG_EN
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
  localparam logic [ADDR_W-1:0] IDX_PREV_LAST = ADDR_W'(DEPTH - 2);
  logic dir_r;
`endif

  logic              valid_s;
  logic              advance_s;
  logic              wr_hit_s;
  logic [ADDR_W-1:0] idx_inc_s;
  logic [ADDR_W-1:0] idx_dec_s;

  // Wrap-around successors of idx and the advance/write qualifiers.
  always_comb begin
    idx_inc_s = (idx_r == IDX_LAST) ? IDX_ZERO : (idx_r + IDX_ONE);
    idx_dec_s = (idx_r == IDX_ZERO) ? IDX_LAST : (idx_r - IDX_ONE);
    if (bus.mode != MODE_ONE_SHOT) begin
      valid_s = bus.enable;
    end else begin
      valid_s = bus.enable && (state_r == RUN);
    end
    advance_s = bus.enable && valid_s;
    wr_hit_s  = bus.wr_en && ({1'b0, bus.wr_addr} < (ADDR_W + 1)'(DEPTH));
  end

  assign bus.seq_out   = table_r[idx_r];
  assign bus.seq_idx   = idx_r;
  assign bus.seq_valid = valid_s;
  assign bus.done      = done_r;

  // Table, index, direction and one-shot FSM state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_r   <= IDX_ZERO;
      state_r <= IDLE;
      done_r  <= 1'b0;
`ifdef SEQGEN_PINGPONG_EN
      dir_r   <= DIR_UP;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        table_r[i] <= WIDTH'(i);
      end
    end else begin
      done_r <= 1'b0;
      if (wr_hit_s) begin
        table_r[bus.wr_addr] <= bus.wr_data;
      end
      if (bus.mode != MODE_ONE_SHOT) begin
        state_r <= IDLE;
      end
`ifdef SEQGEN_PINGPONG_EN
      if (bus.mode != MODE_PINGPONG) begin
        dir_r <= DIR_UP;
      end
`endif
      case (bus.mode)
        MODE_UP_WRAP: begin
          if (advance_s) begin
            idx_r <= idx_inc_s;
          end
        end
        MODE_DOWN_WRAP: begin
          if (advance_s) begin
            idx_r <= idx_dec_s;
          end
        end
`ifdef SEQGEN_PINGPONG_EN
        MODE_PINGPONG: begin
          // Endpoints turn around instead of repeating, so each is emitted once per turn.
          if (advance_s) begin
            if (dir_r == DIR_UP) begin
              if (idx_r == IDX_LAST) begin
                idx_r <= IDX_PREV_LAST;
                dir_r <= DIR_DOWN;
              end else begin
                idx_r <= idx_r + IDX_ONE;
              end
            end else begin
              if (idx_r == IDX_ZERO) begin
                idx_r <= IDX_ONE;
                dir_r <= DIR_UP;
              end else begin
                idx_r <= idx_r - IDX_ONE;
              end
            end
          end
        end
`else
        MODE_PINGPONG: begin
          if (advance_s) begin
            idx_r <= idx_inc_s;
          end
        end
`endif
        MODE_ONE_SHOT: begin
          case (state_r)
            IDLE: begin
              idx_r <= IDX_ZERO;
              if (bus.enable && bus.start) begin
                state_r <= RUN;
              end
            end
            RUN: begin
              if (advance_s) begin
                if (idx_r == IDX_LAST) begin
                  idx_r   <= IDX_ZERO;
                  state_r <= IDLE;
                  done_r  <= 1'b1;
                end else begin
                  idx_r <= idx_r + IDX_ONE;
                end
              end
            end
            default: begin
              state_r <= IDLE;
              idx_r   <= IDX_ZERO;
            end
          endcase
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_prog_sequence_generator.sv
// Directed, table-driven bench for prog_sequence_generator (WIDTH=3, DEPTH=4).
module tb_prog_sequence_generator;
  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  prog_sequence_generator_if #(.WIDTH(3), .DEPTH(4)) bus ();

  prog_sequence_generator #(.WIDTH(3), .DEPTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic       en;
    logic [1:0] md;
    logic       st;
    logic       we;
    logic [1:0] wa;
    logic [2:0] wd;
    logic [2:0] eo;
    logic [1:0] ei;
    logic       ev;
    logic       ed;
  } vec_t;

  vec_t vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic en, input logic [1:0] md, input logic st,
                       input logic we, input logic [1:0] wa, input logic [2:0] wd);
    bus.enable  = en;
    bus.mode    = md;
    bus.start   = st;
    bus.wr_en   = we;
    bus.wr_addr = wa;
    bus.wr_data = wd;
  endtask

  task automatic check_all(input string name, input logic [2:0] eo, input logic [1:0] ei,
                           input logic ev, input logic ed);
    check({name, ".seq_out"},   32'(bus.seq_out),   32'(eo));
    check({name, ".seq_idx"},   32'(bus.seq_idx),   32'(ei));
    check({name, ".seq_valid"}, 32'(bus.seq_valid), 32'(ev));
    check({name, ".done"},      32'(bus.done),      32'(ed));
  endtask

  task automatic step(input string name, input logic en, input logic [1:0] md, input logic st,
                      input logic we, input logic [1:0] wa, input logic [2:0] wd,
                      input logic [2:0] eo, input logic [1:0] ei, input logic ev, input logic ed);
    drive(en, md, st, we, wa, wd);
    @(posedge clk);
    #1;
    check_all(name, eo, ei, ev, ed);
  endtask

  function automatic vec_t mk(input logic en, input logic [1:0] md, input logic st,
                              input logic we, input logic [1:0] wa, input logic [2:0] wd,
                              input logic [2:0] eo, input logic [1:0] ei, input logic ev,
                              input logic ed);
    vec_t v;
    v.en = en; v.md = md; v.st = st; v.we = we; v.wa = wa; v.wd = wd;
    v.eo = eo; v.ei = ei; v.ev = ev; v.ed = ed;
    return v;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 1'b0, 2'd0, 3'd0);

    // Table load (enable low), then UP_WRAP over two laps of 101,110,011,001.
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 1'b1, 2'd0, 3'b101, 3'b101, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 1'b1, 2'd1, 3'b110, 3'b101, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 1'b1, 2'd2, 3'b011, 3'b101, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 1'b1, 2'd3, 3'b001, 3'b101, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 1'b0, 2'd0, 3'd0, 3'b110, 2'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 1'b0, 2'd0, 3'd0, 3'b011, 2'd2, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 1'b0, 2'd0, 3'd0, 3'b001, 2'd3, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 1'b0, 2'd0, 3'd0, 3'b101, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 1'b0, 2'd0, 3'd0, 3'b110, 2'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 1'b0, 2'd0, 3'd0, 3'b011, 2'd2, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 1'b0, 2'd0, 3'd0, 3'b001, 2'd3, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 1'b0, 2'd0, 3'd0, 3'b101, 2'd0, 1'b1, 1'b0));
    // DOWN_WRAP with a stall: 0 -> 3, hold 3, -> 2.
    vecs.push_back(mk(1'b1, 2'b01, 1'b0, 1'b0, 2'd0, 3'd0, 3'b001, 2'd3, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 2'b01, 1'b0, 1'b0, 2'd0, 3'd0, 3'b001, 2'd3, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 2'b01, 1'b0, 1'b0, 2'd0, 3'd0, 3'b011, 2'd2, 1'b1, 1'b0));
    // Mode 10 from idx 2 with dir up.
`ifdef SEQGEN_PINGPONG_EN
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 1'b0, 2'd0, 3'd0, 3'b001, 2'd3, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 1'b0, 2'd0, 3'd0, 3'b011, 2'd2, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 1'b0, 2'd0, 3'd0, 3'b110, 2'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 1'b0, 2'd0, 3'd0, 3'b101, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 1'b0, 2'd0, 3'd0, 3'b110, 2'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 1'b0, 2'd0, 3'd0, 3'b011, 2'd2, 1'b1, 1'b0));
`else
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 1'b0, 2'd0, 3'd0, 3'b001, 2'd3, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 1'b0, 2'd0, 3'd0, 3'b101, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 1'b0, 2'd0, 3'd0, 3'b110, 2'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 1'b0, 2'd0, 3'd0, 3'b011, 2'd2, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 1'b0, 2'd0, 3'd0, 3'b001, 2'd3, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 1'b0, 2'd0, 3'd0, 3'b101, 2'd0, 1'b1, 1'b0));
`endif

    // Reset state, checked while reset is held.
    #12;
    check_all("reset", 3'd0, 2'd0, 1'b0, 1'b0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].en, vecs[i].md, vecs[i].st, vecs[i].we,
           vecs[i].wa, vecs[i].wd, vecs[i].eo, vecs[i].ei, vecs[i].ev, vecs[i].ed);
    end

    // One-shot pass: IDLE forces idx 0, start, stall, ignored restart, done pulse.
    step("os_idle",  1'b1, 2'b11, 1'b0, 1'b0, 2'd0, 3'd0, 3'b101, 2'd0, 1'b0, 1'b0);
    step("os_start", 1'b1, 2'b11, 1'b1, 1'b0, 2'd0, 3'd0, 3'b101, 2'd0, 1'b1, 1'b0);
    step("os_1",     1'b1, 2'b11, 1'b0, 1'b0, 2'd0, 3'd0, 3'b110, 2'd1, 1'b1, 1'b0);
    step("os_2",     1'b1, 2'b11, 1'b1, 1'b0, 2'd0, 3'd0, 3'b011, 2'd2, 1'b1, 1'b0);
    step("os_stall", 1'b0, 2'b11, 1'b0, 1'b0, 2'd0, 3'd0, 3'b011, 2'd2, 1'b0, 1'b0);
    step("os_3",     1'b1, 2'b11, 1'b0, 1'b0, 2'd0, 3'd0, 3'b001, 2'd3, 1'b1, 1'b0);
    step("os_done",  1'b1, 2'b11, 1'b0, 1'b0, 2'd0, 3'd0, 3'b101, 2'd0, 1'b0, 1'b1);
    step("os_after", 1'b1, 2'b11, 1'b0, 1'b0, 2'd0, 3'd0, 3'b101, 2'd0, 1'b0, 1'b0);

    // Write on the advancing edge, then a write to the current idx.
    step("wa_hold",  1'b0, 2'b00, 1'b0, 1'b0, 2'd0, 3'd0, 3'b101, 2'd0, 1'b0, 1'b0);
    step("wa_1",     1'b1, 2'b00, 1'b0, 1'b0, 2'd0, 3'd0, 3'b110, 2'd1, 1'b1, 1'b0);
    step("wa_adv",   1'b1, 2'b00, 1'b0, 1'b1, 2'd2, 3'b111, 3'b111, 2'd2, 1'b1, 1'b0);
    step("wa_cur",   1'b0, 2'b00, 1'b0, 1'b1, 2'd2, 3'b100, 3'b100, 2'd2, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a one-shot pass at idx 2.
    step("ar_start", 1'b1, 2'b11, 1'b1, 1'b0, 2'd0, 3'd0, 3'b101, 2'd0, 1'b1, 1'b0);
    step("ar_1",     1'b1, 2'b11, 1'b1, 1'b0, 2'd0, 3'd0, 3'b110, 2'd1, 1'b1, 1'b0);
    step("ar_2",     1'b1, 2'b11, 1'b1, 1'b0, 2'd0, 3'd0, 3'b100, 2'd2, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_all("ar_reset", 3'd0, 2'd0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("ar_restart", 3'd0, 2'd0, 1'b1, 1'b0);
    step("ar_tbl1",  1'b1, 2'b11, 1'b0, 1'b0, 2'd0, 3'd0, 3'd1, 2'd1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
